mips_muldiv_unit: RTL

//  Parametrised iterative multiply/divide unit for the pipelined MIPS32 core's EX stage.
//  - Replaces the single-cycle MUL and adds MULHI, DIV and REM.
//  - Multi-cycle operation with a valid/ready handshake on both the operand side and the result side.
//  - Carries a destination-register tag so the forwarding and stall units can track the

---
 rtl/mips_muldiv_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the MIPS32 EX stage: shift-add MUL(LO/HI),
// restoring DIV/REM, one bit per clock, with valid/ready handshakes, a destination tag and flush.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             div_by_zero,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;

    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_prod_nx;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_res;

    // r_acc holds {product high, multiplier} for MUL, and the dividend/quotient in its low half for DIV.
    always_comb begin
        w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_prod_nx = {w_add, r_acc[WIDTH-1:1]};
        w_rem_sh  = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_b});
        w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_b}) : w_rem_sh;
        w_quo_nx  = {r_acc[WIDTH-2:0], w_ge};
        case (r_op)
            2'b00:   w_res = w_prod_nx[WIDTH-1:0];
            2'b01:   w_res = w_prod_nx[2*WIDTH-1:WIDTH];
            2'b10:   w_res = w_quo_nx;
            default: w_res = w_rem_nx[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            result      <= '0;
            tag_out     <= '0;
            res_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else if (flush) begin
            r_state     <= S_IDLE;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_op        <= op;
                        r_a         <= opa;
                        r_b         <= opb;
                        r_tag       <= tag_in;
                        r_cnt       <= '0;
                        r_rem       <= '0;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        if (op[1] && (opb == '0)) begin
                            r_state <= S_DONE;
                            r_acc   <= '0;
                        end else begin
                            r_state <= S_CALC;
                            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? opa : opb)};
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[1]) begin
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_quo_nx};
                        r_rem <= w_rem_nx;
                    end else begin
                        r_acc <= w_prod_nx;
                    end
                    if (r_cnt == LAST) begin
                        r_state     <= S_DONE;
                        res_valid   <= 1'b1;
                        result      <= w_res;
                        tag_out     <= r_tag;
                        div_by_zero <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Only the divide-by-zero path enters DONE without a result; publish it one edge later.
                    if (!res_valid) begin
                        res_valid   <= 1'b1;
                        result      <= r_op[0] ? r_a : '1;
                        tag_out     <= r_tag;
                        div_by_zero <= 1'b1;
                    end else if (res_ready) begin
                        r_state     <= S_IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
